// File: rtl/otp_ctrl_otp_arb_if.sv
// Bundle of agent-side and macro-side signals for the OTP macro port arbiter.
// The slave modport is the arbiter; the master modport is the agents plus macro.
interface otp_ctrl_otp_arb_if #(
    parameter int NumReq = 4,
    parameter int CmdW   = 3,
    parameter int SizeW  = 2,
    parameter int IfW    = 32,
    parameter int AddrW  = 11,
    parameter int RdataW = 64,
    parameter int ErrW   = 3
);
    // agent side
    logic [NumReq-1:0]            req_i;
    logic [NumReq-1:0][CmdW-1:0]  cmd_i;
    logic [NumReq-1:0][SizeW-1:0] size_i;
    logic [NumReq-1:0][IfW-1:0]   wdata_i;
    logic [NumReq-1:0][AddrW-1:0] addr_i;
    logic [NumReq-1:0]            gnt_o;
    logic [NumReq-1:0]            rvalid_o;
    logic [RdataW-1:0]            rdata_o;
    logic [ErrW-1:0]              err_o;
    // macro side
    logic                         otp_req_o;
    logic [CmdW-1:0]              otp_cmd_o;
    logic [SizeW-1:0]             otp_size_o;
    logic [IfW-1:0]               otp_wdata_o;
    logic [AddrW-1:0]             otp_addr_o;
    logic                         otp_gnt_i;
    logic                         otp_rvalid_i;
    logic [RdataW-1:0]            otp_rdata_i;
    logic [ErrW-1:0]              otp_err_i;
    // status
    logic                         rsp_err_o;
    logic                         idle_o;

    modport slave (
        input  req_i, cmd_i, size_i, wdata_i, addr_i,
        input  otp_gnt_i, otp_rvalid_i, otp_rdata_i, otp_err_i,
        output gnt_o, rvalid_o, rdata_o, err_o,
        output otp_req_o, otp_cmd_o, otp_size_o, otp_wdata_o, otp_addr_o,
        output rsp_err_o, idle_o
    );

    modport master (
        output req_i, cmd_i, size_i, wdata_i, addr_i,
        output otp_gnt_i, otp_rvalid_i, otp_rdata_i, otp_err_i,
        input  gnt_o, rvalid_o, rdata_o, err_o,
        input  otp_req_o, otp_cmd_o, otp_size_o, otp_wdata_o, otp_addr_o,
        input  rsp_err_o, idle_o
    );
endinterface

// File: rtl/otp_ctrl_otp_arb.sv
// Round-robin arbiter in front of the single OTP macro port. Grants one agent
// per cycle, remembers granted agent indices in an in-order ID FIFO and routes
// each macro response back to the agent that issued the matching command.
// The idle (no request) command is Read, which is encoded as all-zero.
module otp_ctrl_otp_arb #(
    parameter int NumReq = 4,
    parameter int Depth  = 2
) (
    input logic               clk_i,
    input logic               rst_ni,
    otp_ctrl_otp_arb_if.slave bus
);
    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);
    localparam logic [IdxW:0]   NumReqW  = (IdxW + 1)'(NumReq);
    localparam logic [CntW-1:0] DepthC   = CntW'(Depth);
    localparam logic [PtrW-1:0] LastSlot = PtrW'(Depth - 1);

    logic [IdxW-1:0] ptr_q;
    logic            lock_q;
    logic [IdxW-1:0] lock_idx_q;
    logic [IdxW-1:0] fifo_mem [Depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] cnt_q;

    logic [IdxW-1:0] rr_idx, winner, head;
    logic [IdxW:0]   cand, ptr_nxt;
    logic            rr_found, lock_hit, any_req, fifo_full, fifo_empty;
    logic            grant, push, pop;

    // Scan upward from the round-robin pointer for the first requesting agent.
    always_comb begin
        rr_idx   = ptr_q;
        rr_found = 1'b0;
        cand     = '0;
        for (int i = 0; i < NumReq; i++) begin
            cand = {1'b0, ptr_q} + (IdxW + 1)'(i);
            if (cand >= NumReqW) begin
                cand = cand - NumReqW;
            end
            if (!rr_found && bus.req_i[cand[IdxW-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = cand[IdxW-1:0];
            end
        end
    end

    assign lock_hit   = lock_q && bus.req_i[lock_idx_q];
    assign winner     = lock_hit ? lock_idx_q : rr_idx;
    assign any_req    = |bus.req_i;
    assign fifo_full  = (cnt_q == DepthC);
    assign fifo_empty = (cnt_q == '0);
    assign head       = fifo_mem[rd_ptr_q];

    assign bus.otp_req_o = any_req && !fifo_full;
    assign grant         = bus.otp_req_o && bus.otp_gnt_i;
    assign push          = grant;
    assign pop           = bus.otp_rvalid_i && !fifo_empty;

    assign bus.rdata_o   = bus.otp_rdata_i;
    assign bus.err_o     = bus.otp_err_i;
    assign bus.rsp_err_o = bus.otp_rvalid_i && fifo_empty;
    assign bus.idle_o    = fifo_empty && !any_req;

    assign ptr_nxt = {1'b0, winner} + 1'b1;

    // Forward the winner's payload to the macro, parking on a zeroed Read when idle.
    always_comb begin
        bus.otp_cmd_o   = '0;
        bus.otp_size_o  = '0;
        bus.otp_wdata_o = '0;
        bus.otp_addr_o  = '0;
        bus.gnt_o       = '0;
        bus.rvalid_o    = '0;
        if (bus.otp_req_o) begin
            bus.otp_cmd_o   = bus.cmd_i[winner];
            bus.otp_size_o  = bus.size_i[winner];
            bus.otp_wdata_o = bus.wdata_i[winner];
            bus.otp_addr_o  = bus.addr_i[winner];
        end
        if (grant) begin
            bus.gnt_o[winner] = 1'b1;
        end
        if (pop) begin
            bus.rvalid_o[head] = 1'b1;
        end
    end

    // Advance the round-robin pointer on grants and hold a lock on a waiting winner.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (grant) begin
            ptr_q  <= (ptr_nxt == NumReqW) ? '0 : ptr_nxt[IdxW-1:0];
            lock_q <= 1'b0;
        end else if (bus.otp_req_o) begin
            lock_q     <= 1'b1;
            lock_idx_q <= winner;
        end else if (lock_q && !bus.req_i[lock_idx_q]) begin
            lock_q <= 1'b0;
        end
    end

    // ID FIFO pointers and occupancy; push and pop in one cycle keep the count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == LastSlot) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LastSlot) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // ID FIFO storage; entries are only read while the count says they are valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= winner;
        end
    end
endmodule

// File: tb/tb_otp_ctrl_otp_arb.sv
// Self-checking bench for otp_ctrl_otp_arb: directed scenarios with literal
// expectations plus a randomized phase against a queue-based reference model.
module tb_otp_ctrl_otp_arb;
    localparam int NumReq = 4;
    localparam int Depth  = 2;
    localparam logic [2:0] CmdRead    = 3'd0;
    localparam logic [2:0] CmdWrite   = 3'd1;
    localparam logic [2:0] ErrNone    = 3'd0;
    localparam logic [2:0] ErrEccCorr = 3'd2;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    otp_ctrl_otp_arb_if #(.NumReq(NumReq)) bus ();

    otp_ctrl_otp_arb #(.NumReq(NumReq), .Depth(Depth)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // reference model state
    int  m_ptr;
    bit  m_lock;
    int  m_lock_idx;
    int  m_fifo[$];

    // model expectations for the current cycle
    logic              exp_req;
    int                exp_win;
    logic [NumReq-1:0] exp_gnt;
    logic [NumReq-1:0] exp_rvalid;
    logic              exp_rsp_err;
    logic              exp_idle;
    logic [2:0]        exp_cmd;
    logic [1:0]        exp_size;
    logic [31:0]       exp_wdata;
    logic [10:0]       exp_addr;

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ptr      = 0;
        m_lock     = 1'b0;
        m_lock_idx = 0;
        m_fifo.delete();
        exp_gnt    = '0;
    endfunction

    // Derive this cycle's outputs from the arbitration rules and the ID queue.
    function automatic void model_eval();
        bit any;
        bit found;
        int c;
        any     = (bus.req_i != '0);
        exp_req = any && (m_fifo.size() < Depth);
        exp_win = 0;
        found   = 1'b0;
        if (m_lock && bus.req_i[m_lock_idx]) begin
            exp_win = m_lock_idx;
        end else begin
            for (int k = 0; k < NumReq; k++) begin
                c = (m_ptr + k) % NumReq;
                if (!found && bus.req_i[c]) begin
                    found   = 1'b1;
                    exp_win = c;
                end
            end
        end
        exp_gnt = '0;
        if (exp_req && bus.otp_gnt_i) exp_gnt[exp_win] = 1'b1;
        exp_rvalid = '0;
        if (bus.otp_rvalid_i && m_fifo.size() > 0) exp_rvalid[m_fifo[0]] = 1'b1;
        exp_rsp_err = bus.otp_rvalid_i && (m_fifo.size() == 0);
        exp_idle    = (m_fifo.size() == 0) && !any;
        exp_cmd   = exp_req ? bus.cmd_i[exp_win]   : CmdRead;
        exp_size  = exp_req ? bus.size_i[exp_win]  : 2'd0;
        exp_wdata = exp_req ? bus.wdata_i[exp_win] : 32'd0;
        exp_addr  = exp_req ? bus.addr_i[exp_win]  : 11'd0;
    endfunction

    // Commit the cycle's grant/response into the model at the clock edge.
    function automatic void model_update();
        if (exp_gnt != '0) begin
            m_fifo.push_back(exp_win);
            m_ptr  = (exp_win + 1) % NumReq;
            m_lock = 1'b0;
        end else if (exp_req) begin
            m_lock     = 1'b1;
            m_lock_idx = exp_win;
        end else if (m_lock && !bus.req_i[m_lock_idx]) begin
            m_lock = 1'b0;
        end
        if (exp_rvalid != '0) void'(m_fifo.pop_front());
    endfunction

    task automatic check_output();
        @(negedge clk_i);
        model_eval();
        check_val("otp_req", bus.otp_req_o, exp_req);
        check_val("gnt", bus.gnt_o, exp_gnt);
        check_val("rvalid", bus.rvalid_o, exp_rvalid);
        check_val("rsp_err", bus.rsp_err_o, exp_rsp_err);
        check_val("idle", bus.idle_o, exp_idle);
        check_val("otp_cmd", bus.otp_cmd_o, exp_cmd);
        check_val("otp_size", bus.otp_size_o, exp_size);
        check_val("otp_wdata", bus.otp_wdata_o, exp_wdata);
        check_val("otp_addr", bus.otp_addr_o, exp_addr);
        check_val("rdata", bus.rdata_o, bus.otp_rdata_i);
        check_val("err", bus.err_o, bus.otp_err_i);
    endtask

    task automatic step_clock();
        @(posedge clk_i);
        if (rst_ni) model_update();
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_i        = '0;
        bus.cmd_i        = '0;
        bus.size_i       = '0;
        bus.wdata_i      = '0;
        bus.addr_i       = '0;
        bus.otp_gnt_i    = 1'b0;
        bus.otp_rvalid_i = 1'b0;
        bus.otp_rdata_i  = '0;
        bus.otp_err_i    = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_ni = 1'b0;
        model_reset();
        @(negedge clk_i);
        check_val("rst_otp_req", bus.otp_req_o, 1'b0);
        check_val("rst_gnt", bus.gnt_o, 4'b0000);
        check_val("rst_rvalid", bus.rvalid_o, 4'b0000);
        check_val("rst_rsp_err", bus.rsp_err_o, 1'b0);
        check_val("rst_otp_cmd", bus.otp_cmd_o, CmdRead);
        check_val("rst_idle", bus.idle_o, 1'b1);
        check_val("rst_ptr", dut.ptr_q, 2'd0);
        check_val("rst_cnt", dut.cnt_q, 2'd0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    // Randomized agents: hold req until granted, occasionally drop early.
    task automatic apply_stimulus();
        for (int a = 0; a < NumReq; a++) begin
            if (bus.req_i[a] && exp_gnt[a]) begin
                bus.req_i[a] = 1'b0;
            end else if (bus.req_i[a] && $urandom_range(63) == 0) begin
                bus.req_i[a] = 1'b0;
            end else if (!bus.req_i[a] && $urandom_range(2) == 0) begin
                bus.req_i[a]   = 1'b1;
                bus.cmd_i[a]   = 3'($urandom);
                bus.size_i[a]  = 2'($urandom);
                bus.wdata_i[a] = $urandom;
                bus.addr_i[a]  = 11'($urandom);
            end
        end
        bus.otp_gnt_i    = ($urandom_range(3) != 0);
        bus.otp_rvalid_i = ($urandom_range(2) == 0);
        bus.otp_rdata_i  = {$urandom, $urandom};
        bus.otp_err_i    = 3'($urandom);
    endtask

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};
        logic [NumReq-1:0] onehot;

        clear_inputs();
        #1;

        // single agent
        do_reset();
        bus.req_i = 4'b0100; bus.cmd_i[2] = CmdWrite; bus.addr_i[2] = 11'h10; bus.otp_gnt_i = 1'b1;
        check_output();
        check_val("single_gnt", bus.gnt_o, 4'b0100);
        check_val("single_addr", bus.otp_addr_o, 11'h10);
        check_val("single_cmd", bus.otp_cmd_o, CmdWrite);
        step_clock();
        bus.req_i = '0; bus.otp_gnt_i = 1'b0;
        check_output();
        step_clock();
        bus.otp_rvalid_i = 1'b1; bus.otp_rdata_i = 64'h1122_3344_5566_7788;
        check_output();
        check_val("single_rvalid", bus.rvalid_o, 4'b0100);
        step_clock();
        bus.otp_rvalid_i = 1'b0;
        check_output();
        check_val("single_ptr", dut.ptr_q, 2'd3);
        check_val("single_idle", bus.idle_o, 1'b1);
        step_clock();

        // fairness
        do_reset();
        bus.req_i = 4'b1111; bus.otp_gnt_i = 1'b1;
        for (int a = 0; a < NumReq; a++) bus.addr_i[a] = 11'(a + 1);
        for (int k = 0; k < 5; k++) begin
            bus.otp_rvalid_i = (k > 0);
            check_output();
            onehot = '0;
            onehot[order[k]] = 1'b1;
            check_val($sformatf("fair_gnt_%0d", k), bus.gnt_o, onehot);
            step_clock();
        end
        clear_inputs();
        bus.otp_rvalid_i = 1'b1;
        check_output();
        step_clock();
        bus.otp_rvalid_i = 1'b0;

        // lock
        do_reset();
        bus.req_i = 4'b0010; bus.addr_i[1] = 11'h21;
        for (int k = 0; k < 3; k++) begin
            check_output();
            check_val("lock_wait_addr", bus.otp_addr_o, 11'h21);
            check_val("lock_wait_gnt", bus.gnt_o, 4'b0000);
            step_clock();
        end
        bus.req_i = 4'b0011; bus.addr_i[0] = 11'h30;
        check_output();
        check_val("lock_hold_addr", bus.otp_addr_o, 11'h21);
        step_clock();
        bus.otp_gnt_i = 1'b1;
        check_output();
        check_val("lock_gnt1", bus.gnt_o, 4'b0010);
        step_clock();
        bus.req_i = 4'b0001;
        check_output();
        check_val("lock_gnt0", bus.gnt_o, 4'b0001);
        check_val("lock_addr0", bus.otp_addr_o, 11'h30);
        step_clock();

        // FIFO full
        do_reset();
        bus.otp_gnt_i = 1'b1;
        bus.req_i = 4'b0001; check_output(); step_clock();
        bus.req_i = 4'b0010; check_output(); step_clock();
        bus.req_i = 4'b0100;
        check_output();
        check_val("full_req_blocked", bus.otp_req_o, 1'b0);
        step_clock();
        bus.otp_rvalid_i = 1'b1;
        check_output();
        check_val("full_pop_same_cycle", bus.otp_req_o, 1'b0);
        check_val("full_pop_rvalid", bus.rvalid_o, 4'b0001);
        step_clock();
        bus.otp_rvalid_i = 1'b0;
        check_output();
        check_val("full_unblocked", bus.otp_req_o, 1'b1);
        check_val("full_gnt2", bus.gnt_o, 4'b0100);
        step_clock();
        bus.req_i = '0; bus.otp_gnt_i = 1'b0; bus.otp_rvalid_i = 1'b1;
        check_output(); check_val("full_drain1", bus.rvalid_o, 4'b0010); step_clock();
        check_output(); check_val("full_drain2", bus.rvalid_o, 4'b0100); step_clock();
        bus.otp_rvalid_i = 1'b0;

        // routing, then orphan response
        do_reset();
        bus.otp_gnt_i = 1'b1;
        bus.req_i = 4'b1000; check_output(); step_clock();
        bus.req_i = 4'b0001; check_output(); step_clock();
        bus.req_i = '0; bus.otp_gnt_i = 1'b0;
        bus.otp_rvalid_i = 1'b1; bus.otp_err_i = ErrEccCorr; bus.otp_rdata_i = 64'hDEAD_BEEF_0123_4567;
        check_output();
        check_val("route_rvalid3", bus.rvalid_o, 4'b1000);
        check_val("route_err", bus.err_o, ErrEccCorr);
        check_val("route_rdata", bus.rdata_o, 64'hDEAD_BEEF_0123_4567);
        step_clock();
        bus.otp_err_i = ErrNone;
        check_output();
        check_val("route_rvalid0", bus.rvalid_o, 4'b0001);
        check_val("route_err_none", bus.err_o, ErrNone);
        step_clock();
        check_output();
        check_val("orphan_rsp_err", bus.rsp_err_o, 1'b1);
        check_val("orphan_rvalid", bus.rvalid_o, 4'b0000);
        step_clock();
        bus.otp_rvalid_i = 1'b0;
        check_output();
        check_val("orphan_pulse_end", bus.rsp_err_o, 1'b0);
        step_clock();

        // reset with two outstanding commands, then a late response
        bus.otp_gnt_i = 1'b1;
        bus.req_i = 4'b0010; check_output(); step_clock();
        bus.req_i = 4'b0100; check_output(); step_clock();
        do_reset();
        bus.otp_rvalid_i = 1'b1;
        check_output();
        check_val("late_rsp_err", bus.rsp_err_o, 1'b1);
        check_val("late_rvalid", bus.rvalid_o, 4'b0000);
        step_clock();
        bus.otp_rvalid_i = 1'b0;

        // randomized traffic with a reset in the middle
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            apply_stimulus();
            check_output();
            step_clock();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/otp_ctrl_otp_arb.md
# otp_ctrl_otp_arb

Round-robin arbiter between the OTP controller's request agents (LCI, DAI, partition readers) and the single prim_otp macro port. Grants one command at a time and forwards its payload to the macro. Records the granted agent's index in a small in-order FIFO and routes each macro response back to the agent that issued it. Directly downstream of the LCI, which is one of its requestors.

## Interface
- NumReq, default 4: number of requesting agents (≥2); index width IdxW = vbits(NumReq).
- Depth, default 2: maximum outstanding granted-but-unanswered commands (≥1).
- clk_i, input, 1: clock.
- rst_ni, input, 1: reset. Asynchronous assertion, active-low.
- req_i, input, [NumReq]: per-agent request level. Held until that agent's gnt_o.
- cmd_i, input, [NumReq] x prim_otp_pkg::cmd_e: per-agent command.
- size_i, input, [NumReq] x OtpSizeWidth: per-agent size.
- wdata_i, input, [NumReq] x OtpIfWidth: per-agent write data.
- addr_i, input, [NumReq] x OtpAddrWidth: per-agent address.
- gnt_o, output, [NumReq]: one-hot grant.
- rvalid_o, output, [NumReq]: one-hot response strobe.
- rdata_o, output, ScrmblBlockWidth: response data, broadcast to all agents.
- err_o, output, prim_otp_pkg::err_e: response error code, broadcast to all agents.
- otp_req_o, output, 1: request to the macro.
- otp_cmd_o, output, cmd_e: command to the macro.
- otp_size_o, output, OtpSizeWidth: size to the macro.
- otp_wdata_o, output, OtpIfWidth: write data to the macro.
- otp_addr_o, output, OtpAddrWidth: address to the macro.
- otp_gnt_i, input, 1: macro grant.
- otp_rvalid_i, input, 1: macro response valid.
- otp_rdata_i, input, ScrmblBlockWidth: macro response data.
- otp_err_i, input, err_e: macro response error code.
- rsp_err_o, output, 1: single-cycle pulse when a response arrives with no outstanding command.
- idle_o, output, 1: high when the FIFO is empty and no req_i is set.

## Operation
- State: round-robin pointer ptr_q (IdxW bits), lock flag lock_q, locked index lock_idx_q, and an ID FIFO of Depth entries x IdxW with its count.
- Winner selection:
  - If lock_q is set and req_i[lock_idx_q] is high, the winner is lock_idx_q.
  - Otherwise the winner is the first set req_i scanning upward from ptr_q, wrapping modulo NumReq.
- otp_req_o = (any req_i set) AND NOT fifo_full.
- When otp_req_o = 1: cmd/size/wdata/addr outputs carry the winner's inputs.
- When otp_req_o = 0: otp_cmd_o = Read; otp_size_o, otp_wdata_o, otp_addr_o = 0.
- gnt_o[winner] = otp_req_o AND otp_gnt_i. All other gnt_o bits are 0.
- On a grant:
  - push winner index into the FIFO;
  - ptr_q <= (winner+1) mod NumReq;
  - clear lock_q.
- On otp_req_o=1 without otp_gnt_i: lock_q <= 1 and lock_idx_q <= winner. This keeps the macro-side request stable until granted.
- Locked agent drops req_i before its grant (protocol violation): clear the lock and resume normal round-robin the same cycle. No error is flagged.
- On otp_rvalid_i with the FIFO non-empty:
  - rvalid_o[head] = 1 and pop the head;
  - rdata_o = otp_rdata_i and err_o = otp_err_i; both pass through unconditionally.
- On otp_rvalid_i with the FIFO empty: rsp_err_o = 1, no rvalid_o bit set, FIFO unchanged.
- Push and pop in the same cycle: count is unchanged and both pointers advance. This is allowed only when the FIFO was not full, since a full FIFO blocks the request.
- fifo_full is decoded from the registered count. A pop does not unblock a request in the same cycle.

## Timing
- Reset values:
  - ptr_q = 0, lock_q = 0, FIFO empty;
  - all gnt_o, rvalid_o, otp_req_o, rsp_err_o = 0;
  - otp_cmd_o = Read, idle_o = 1.
- Request path is combinational, zero latency: req_i to otp_req_o in the same cycle, and otp_gnt_i to gnt_o in the same cycle.
- Response path is combinational, zero latency: otp_rvalid_i to rvalid_o in the same cycle. Responses return in grant order.
- Throughput is one grant per cycle while the FIFO is not full.
- With FIFO full, otp_req_o stays low until the cycle after a pop.
- Reset mid-transaction clears all state. Late macro responses after reset produce rsp_err_o pulses.

## Test plan
- Single agent:
  - stimulus: req_i[2]=1 with addr 0x10, cmd Write; otp_gnt_i=1 the same cycle; otp_rvalid_i two cycles later;
  - response: gnt_o=0b0100, otp_addr_o=0x10, then rvalid_o=0b0100; ptr_q becomes 3.
- Fairness:
  - stimulus: all four req_i held high, otp_gnt_i=1 every cycle;
  - response: grants in order 0,1,2,3,0; no agent granted twice within any 4 consecutive grants.
- Lock:
  - stimulus: req_i[1] wins with gnt low for 3 cycles, then req_i[0] also asserts;
  - response: the macro-side payload stays on agent 1 until its grant; agent 0 is granted next.
- FIFO full (Depth=2):
  - stimulus: two grants with no responses;
  - response: otp_req_o=0 while any req_i is pending; after one otp_rvalid_i, otp_req_o=1 the following cycle.
- Routing:
  - stimulus: grant agent 3 then agent 0; rvalid with err=MacroEccCorrError, then NoError;
  - response: rvalid_o=0b1000 carrying the error code, then rvalid_o=0b0001.
- Orphan response and reset:
  - stimulus: otp_rvalid_i with the FIFO empty; separately, assert rst_ni low while 2 commands are outstanding;
  - response: rsp_err_o pulses for 1 cycle with no rvalid_o; after the reset the FIFO is empty, idle_o=1 and ptr_q=0.
